// File: rtl/keypad_fifo_if.sv
// keypad_fifo_if: bundles the scanner, control and consumer signals of
// keypad_fifo.
//   master : scanner/consumer side (drives code, strobe, clear, key_ready)
//   slave  : keypad_fifo side (drives key_out, key_valid, level, overflow)
// CODE_W and DEPTH must match the keypad_fifo instance that uses it.
interface keypad_fifo_if #(
  parameter int CODE_W = 4,
  parameter int DEPTH  = 4
);
  logic [CODE_W-1:0]          keypad_input;
  logic                       keypad_input_enable;
  logic                       clear;
  logic [CODE_W-1:0]          key_out;
  logic                       key_valid;
  logic                       key_ready;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic                       overflow;

  modport master (
    output keypad_input, keypad_input_enable, clear, key_ready,
    input  key_out, key_valid, level, overflow
  );

  modport slave (
    input  keypad_input, keypad_input_enable, clear, key_ready,
    output key_out, key_valid, level, overflow
  );
endinterface

// File: rtl/keypad_fifo.sv
// keypad_fifo: synchronises and debounces the keypad scanner strobe, drops
// zero codes and buffers accepted codes in a DEPTH-entry FIFO presented on a
// valid/ready handshake. A sticky overflow flag records codes dropped on full.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : keypad_fifo_if.slave (keypad_input, keypad_input_enable, clear,
//              key_ready in; key_out, key_valid, level, overflow out)
//
// Optional build macro: KEYPAD_DUP_FILTER_EN discards a non-zero accepted
// code equal to the previous non-zero accepted code.
module keypad_fifo #(
  parameter int CODE_W       = 4,
  parameter int DEPTH        = 4,
  parameter int DEBOUNCE_CYC = 3
) (
  input logic          clk,
  input logic          reset_n,
  keypad_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic {ARMED, WAIT_LOW} det_state_e;

  // Strobe synchroniser and debounce detector
  logic             en_meta_q, en_s_q;
  det_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_meta_q <= 1'b0;
      en_s_q    <= 1'b0;
      state_q   <= ARMED;
      cnt_q     <= '0;
    end else begin
      en_meta_q <= bus.keypad_input_enable;
      en_s_q    <= en_meta_q;
      case (state_q)
        ARMED: begin
          if (!en_s_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= WAIT_LOW;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_LOW: if (!en_s_q) state_q <= ARMED;
        default:  state_q <= ARMED;
      endcase
    end
  end

  // The accept event coincides with the edge that moves ARMED -> WAIT_LOW,
  // so keypad_input is sampled into the FIFO on that same edge.
  assign accept = (state_q == ARMED) && en_s_q && (cnt_q == CNT_LAST);

  // FIFO storage and bookkeeping
  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CODE_W-1:0] key_out_q, key_out_d;
  logic              overflow_q, overflow_d;
  logic              nz_accept, push_req, pop, full, do_push;

  assign nz_accept = accept && (bus.keypad_input != '0);

`ifdef KEYPAD_DUP_FILTER_EN
  logic [CODE_W-1:0] last_q, last_d;

  assign push_req = nz_accept && (bus.keypad_input != last_q);

  always_comb begin
    last_d = last_q;
    if (bus.clear)      last_d = '0;
    else if (nz_accept) last_d = bus.keypad_input;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= '0;
    else          last_q <= last_d;
  end
`else
  assign push_req = nz_accept;
`endif

  assign pop     = (level_q != '0) && bus.key_ready;
  assign full    = (level_q == FULL_LVL);
  assign do_push = push_req && (!full || pop);
  assign rd_next = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    key_out_d  = key_out_q;
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      key_out_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_next;
      case ({do_push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (push_req && !do_push) overflow_d = 1'b1;
      // Registered head: the incoming code becomes the head when the FIFO is
      // (or becomes) otherwise empty; a pop exposes the entry behind the head.
      if (level_d == '0)
        key_out_d = '0;
      else if (do_push && ((level_q == '0) || (pop && (level_q == LVL_W'(1)))))
        key_out_d = bus.keypad_input;
      else if (pop)
        key_out_d = mem_q[rd_next];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      key_out_q  <= '0;
    end else begin
      if (!bus.clear && do_push) mem_q[wr_ptr_q] <= bus.keypad_input;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      key_out_q  <= key_out_d;
    end
  end

  assign bus.key_out   = key_out_q;
  assign bus.key_valid = (level_q != '0);
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_fifo.sv
module tb_keypad_fifo;
  localparam int CODE_W = 4;
  localparam int DEPTH  = 4;
  localparam int DEB    = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  keypad_fifo_if #(.CODE_W(CODE_W), .DEPTH(DEPTH)) bus ();

  keypad_fifo #(.CODE_W(CODE_W), .DEPTH(DEPTH), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic [3:0] code, input int high);
    bus.keypad_input        = code;
    bus.keypad_input_enable = 1'b1;
    tick(high);
    bus.keypad_input_enable = 1'b0;
    tick(4);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    bus.keypad_input = '0; bus.keypad_input_enable = 1'b0;
    bus.clear = 1'b0; bus.key_ready = 1'b0;
    reset_n = 1'b0;
    tick(2);
    n_cmp++; if (bus.key_out !== 4'h0) begin n_fail++; $display("FAIL reset_key_out: got %0h want 0", bus.key_out); end
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %0b want 0", bus.key_valid); end
    n_cmp++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", bus.overflow); end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    bus.keypad_input = 4'h5; bus.keypad_input_enable = 1'b1;
    tick(4);
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b want 0", bus.key_valid); end
    tick(1);
    n_cmp++; if (bus.key_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", bus.key_valid); end
    n_cmp++; if (bus.key_out !== 4'h5) begin n_fail++; $display("FAIL single_key_out: got %0h want 5", bus.key_out); end
    n_cmp++; if (bus.level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", bus.level); end
    tick(5);
    bus.keypad_input_enable = 1'b0;
    tick(4);
    n_cmp++; if (bus.level !== 3'd1) begin n_fail++; $display("FAIL single_one_entry: got %0d want 1", bus.level); end
    bus.key_ready = 1'b1; tick(1); bus.key_ready = 1'b0;
    n_cmp++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL single_pop_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %0b want 0", bus.key_valid); end
    n_cmp++; if (bus.key_out !== 4'h0) begin n_fail++; $display("FAIL single_pop_key_out: got %0h want 0", bus.key_out); end
  endtask

  task automatic test_glitch();
    strobe(4'h7, 2);
    n_cmp++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL glitch_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %0b want 0", bus.key_valid); end
  endtask

  task automatic test_zero_code();
    strobe(4'h0, 6);
    n_cmp++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL zero_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL zero_overflow: got %0b want 0", bus.overflow); end
  endtask

  task automatic test_fill_overflow();
    logic [3:0] exp [4];
    exp[0] = 4'h1; exp[1] = 4'h2; exp[2] = 4'h3; exp[3] = 4'h4;
    for (int i = 0; i < 4; i++) strobe(exp[i], 6);
    n_cmp++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL fill_level: got %0d want 4", bus.level); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_overflow: got %0b want 0", bus.overflow); end
    strobe(4'h9, 6);
    n_cmp++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", bus.level); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.key_out !== exp[i]) begin n_fail++; $display("FAIL ovf_pop%0d: got %0h want %0h", i, bus.key_out, exp[i]); end
      bus.key_ready = 1'b1; tick(1); bus.key_ready = 1'b0;
      tick(1);
    end
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %0b want 0", bus.key_valid); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", bus.overflow); end
    pulse_clear();
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b want 0", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp [4];
    for (int i = 1; i <= 4; i++) strobe(4'(i), 6);
    // accept of code 6 happens on the 5th edge after the strobe rises
    bus.keypad_input = 4'h6; bus.keypad_input_enable = 1'b1;
    tick(4);
    bus.key_ready = 1'b1; tick(1); bus.key_ready = 1'b0;
    n_cmp++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL fpp_level: got %0d want 4", bus.level); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %0b want 0", bus.overflow); end
    n_cmp++; if (bus.key_out !== 4'h2) begin n_fail++; $display("FAIL fpp_head: got %0h want 2", bus.key_out); end
    tick(1);
    bus.keypad_input_enable = 1'b0;
    tick(4);
    exp[0] = 4'h2; exp[1] = 4'h3; exp[2] = 4'h4; exp[3] = 4'h6;
    bus.key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.key_out !== exp[i]) begin n_fail++; $display("FAIL b2b_pop%0d: got %0h want %0h", i, bus.key_out, exp[i]); end
      tick(1);
    end
    bus.key_ready = 1'b0;
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %0b want 0", bus.key_valid); end
    strobe(4'h7, 6);
    strobe(4'h8, 6);
    n_cmp++; if (bus.level !== 3'd2) begin n_fail++; $display("FAIL pre_clear_level: got %0d want 2", bus.level); end
    pulse_clear();
    n_cmp++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL clear_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.key_out !== 4'h0) begin n_fail++; $display("FAIL clear_key_out: got %0h want 0", bus.key_out); end
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %0b want 0", bus.key_valid); end
  endtask

  task automatic test_clear_vs_push();
    bus.keypad_input = 4'hA; bus.keypad_input_enable = 1'b1;
    tick(4);
    bus.clear = 1'b1; tick(1); bus.clear = 1'b0;
    n_cmp++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL clrpush_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL clrpush_overflow: got %0b want 0", bus.overflow); end
    tick(1);
    bus.keypad_input_enable = 1'b0;
    tick(4);
  endtask

  task automatic test_dup_filter();
    logic [3:0] exp [3];
    int         n_exp;
    strobe(4'h3, 6);
    strobe(4'h3, 6);
    strobe(4'h4, 6);
`ifdef KEYPAD_DUP_FILTER_EN
    n_exp = 2; exp[0] = 4'h3; exp[1] = 4'h4; exp[2] = 4'h0;
`else
    n_exp = 3; exp[0] = 4'h3; exp[1] = 4'h3; exp[2] = 4'h4;
`endif
    n_cmp++; if (bus.level !== 3'(n_exp)) begin n_fail++; $display("FAIL dup_level: got %0d want %0d", bus.level, n_exp); end
    for (int i = 0; i < n_exp; i++) begin
      n_cmp++; if (bus.key_out !== exp[i]) begin n_fail++; $display("FAIL dup_pop%0d: got %0h want %0h", i, bus.key_out, exp[i]); end
      bus.key_ready = 1'b1; tick(1); bus.key_ready = 1'b0;
    end
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL dup_drained: got %0b want 0", bus.key_valid); end
  endtask

  task automatic test_reset_mid_strobe();
    strobe(4'h5, 6);
    bus.keypad_input = 4'h8; bus.keypad_input_enable = 1'b1;
    tick(3);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL rst_mid_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %0b want 0", bus.key_valid); end
    n_cmp++; if (bus.key_out !== 4'h0) begin n_fail++; $display("FAIL rst_mid_key_out: got %0h want 0", bus.key_out); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overflow: got %0b want 0", bus.overflow); end
    tick(2);
    reset_n = 1'b1;
    tick(4);
    n_cmp++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rel_early: got %0b want 0", bus.key_valid); end
    tick(1);
    n_cmp++; if (bus.key_valid !== 1'b1) begin n_fail++; $display("FAIL rst_rel_valid: got %0b want 1", bus.key_valid); end
    n_cmp++; if (bus.key_out !== 4'h8) begin n_fail++; $display("FAIL rst_rel_key_out: got %0h want 8", bus.key_out); end
    bus.keypad_input_enable = 1'b0;
    tick(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_zero_code();
    test_fill_overflow();
    test_full_push_pop();
    test_clear_vs_push();
    test_dup_filter();
    test_reset_mid_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
